// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// status-register codes and the default iteration count.
package muldiv_pkg;

  // FSM state encoding
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  // Status-register values written on exceptions
  localparam logic [31:0] STATUS_MULT_OVF = 32'd1;
  localparam logic [31:0] STATUS_DIV_ZERO = 32'd2;

  localparam int unsigned MULDIV_ITER_DEFAULT = 32;

  // Counter width for a given step count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/muldiv_iter_counter.sv
// Loadable down-counter with a zero flag. Holds at zero instead of wrapping.
module muldiv_iter_counter #(
  parameter int unsigned CW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the iterative mult/div datapath behind the execute stage.
// Stalls the front end while the datapath steps, then emits one writeback
// strobe plus an optional status-register write.
// Build option MULDIV_EARLY_OUT_EN: multiplies with a zero operand skip the
// datapath and finish in one cycle with a zero result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ITER_CYCLES = MULDIV_ITER_DEFAULT,
  parameter int unsigned REG_BITS    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue,
  input  logic                is_div,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic [REG_BITS-1:0] dest,
  output logic                stall,
  output logic                busy,
  output logic                dp_start,
  output logic                dp_is_div,
  output logic [WIDTH-1:0]    dp_a,
  output logic [WIDTH-1:0]    dp_b,
  output logic                dp_step,
  input  logic [WIDTH-1:0]    dp_result,
  input  logic                dp_overflow,
  output logic                wb_valid,
  output logic [WIDTH-1:0]    wb_data,
  output logic [REG_BITS-1:0] wb_reg,
  output logic                status_wren,
  output logic [31:0]         status_data
);

  localparam int unsigned   CW      = cnt_width(ITER_CYCLES);
  localparam logic [CW-1:0] LoadVal = CW'(ITER_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic                div0_q, div0_d;
  // Result is forced to zero (divide by zero or multiply early-out).
  logic                zero_res_q, zero_res_d;
  logic                is_div_q, is_div_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [REG_BITS-1:0] reg_q, reg_d;

  logic          accept, div0, early, cnt_load, cnt_zero, in_run, in_finish, mult_ovf;
  logic [CW-1:0] cnt;

  assign in_run    = (state_q == StRun);
  assign in_finish = (state_q == StFinish);
  // FINISH accepts a new issue exactly like IDLE (back-to-back).
  assign accept    = issue && ((state_q == StIdle) || in_finish);
  assign div0      = is_div && (op_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = !is_div && ((op_a == '0) || (op_b == '0));
`else
  assign early = 1'b0;
`endif

  muldiv_iter_counter #(
    .CW (CW)
  ) u_iter_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LoadVal),
    .en       (in_run),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Next-state and operand-latch logic.
  always_comb begin
    state_d    = state_q;
    div0_d     = div0_q;
    zero_res_d = zero_res_q;
    is_div_d   = is_div_q;
    a_d        = a_q;
    b_d        = b_q;
    reg_d      = reg_q;
    cnt_load   = 1'b0;
    case (state_q)
      StRun:   if (cnt_zero) state_d = StFinish;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      a_d        = op_a;
      b_d        = op_b;
      is_div_d   = is_div;
      reg_d      = dest;
      div0_d     = div0;
      zero_res_d = div0 || early;
      if (div0 || early) begin
        state_d = StFinish;
      end else begin
        state_d  = StRun;
        cnt_load = 1'b1;
      end
    end
  end

  // State and latched-operand registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      div0_q     <= 1'b0;
      zero_res_q <= 1'b0;
      is_div_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      reg_q      <= '0;
    end else begin
      state_q    <= state_d;
      div0_q     <= div0_d;
      zero_res_q <= zero_res_d;
      is_div_q   <= is_div_d;
      a_q        <= a_d;
      b_q        <= b_d;
      reg_q      <= reg_d;
    end
  end

  // Overflow only counts for a multiply that actually went through the datapath.
  assign mult_ovf = !is_div_q && dp_overflow && !zero_res_q;

  // Control and writeback outputs, decoded from state.
  always_comb begin
    stall       = in_run || accept;
    busy        = in_run;
    dp_step     = in_run;
    // Counter still holds its load value only in the first RUN cycle.
    dp_start    = in_run && (cnt == LoadVal);
    wb_valid    = in_finish;
    wb_data     = (in_finish && !zero_res_q) ? dp_result : '0;
    status_wren = in_finish && (div0_q || mult_ovf);
    status_data = '0;
    if (in_finish) begin
      if (div0_q)        status_data = STATUS_DIV_ZERO;
      else if (mult_ovf) status_data = STATUS_MULT_OVF;
    end
  end

  assign dp_is_div = is_div_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign wb_reg    = reg_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table of directed mult/div vectors against a
// behavioural datapath, plus back-to-back and reset-abort sequences.
// Expectations follow MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_muldiv_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned IC = 32;
  localparam int unsigned RB = 5;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          issue = 1'b0;
  logic          is_div = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [RB-1:0] dest = '0;
  logic          stall, busy, dp_start, dp_is_div, dp_step;
  logic [W-1:0]  dp_a, dp_b, dp_result, wb_data;
  logic          dp_overflow, wb_valid, status_wren;
  logic [RB-1:0] wb_reg;
  logic [31:0]   status_data;

  always #5 clock = ~clock;

  muldiv_sequencer #(
    .WIDTH       (W),
    .ITER_CYCLES (IC),
    .REG_BITS    (RB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue       (issue),
    .is_div      (is_div),
    .op_a        (op_a),
    .op_b        (op_b),
    .dest        (dest),
    .stall       (stall),
    .busy        (busy),
    .dp_start    (dp_start),
    .dp_is_div   (dp_is_div),
    .dp_a        (dp_a),
    .dp_b        (dp_b),
    .dp_step     (dp_step),
    .dp_result   (dp_result),
    .dp_overflow (dp_overflow),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_reg      (wb_reg),
    .status_wren (status_wren),
    .status_data (status_data)
  );

  // Behavioural datapath: computes on dp_start, holds until the next start.
  // Overflow is driven high for divides to check that it is ignored there.
  logic [63:0] prod;
  assign prod = {32'd0, dp_a} * {32'd0, dp_b};
  always @(posedge clock) begin
    if (reset) begin
      dp_result   <= '0;
      dp_overflow <= 1'b0;
    end else if (dp_start) begin
      dp_result   <= dp_is_div ? ((dp_b == '0) ? '0 : dp_a / dp_b) : prod[31:0];
      dp_overflow <= dp_is_div | (prod[63:32] != 32'd0);
    end
  end

  typedef struct {
    logic          is_div;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RB-1:0] dest;
    int            lat;
    logic [W-1:0]  data;
    logic          wren;
    logic [31:0]   status;
    int            starts;
    int            steps;
  } vec_t;

  vec_t vecs[7];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Drive an issue for one cycle starting now (caller is at a negedge).
  task automatic issue_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [RB-1:0] r, input string tag);
    issue = 1'b1; is_div = d; op_a = a; op_b = b; dest = r;
    #1 check($sformatf("%s stall_at_issue", tag), 64'(stall), 64'd1);
    @(posedge clock); #1;
    issue = 1'b0; is_div = 1'b0; op_a = '0; op_b = '0; dest = '0;
  endtask

  // Observe cycles after the issue cycle until wb_valid (bounded).
  task automatic watch(output int lat, output int starts, output int start_at, output int steps,
                       output logic stall_bad, output logic [W-1:0] data,
                       output logic [RB-1:0] r, output logic wren, output logic [31:0] st);
    lat = 0; starts = 0; start_at = 0; steps = 0; stall_bad = 1'b0;
    data = '0; r = '0; wren = 1'b0; st = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (dp_start === 1'b1) begin starts++; start_at = c; end
      if (dp_step === 1'b1) steps++;
      if (stall === wb_valid) stall_bad = 1'b1;
      if (wb_valid === 1'b1) begin
        lat = c; data = wb_data; r = wb_reg; wren = status_wren; st = status_data;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check($sformatf("%s stall", tag),       64'(stall),       64'd0);
    check($sformatf("%s busy", tag),        64'(busy),        64'd0);
    check($sformatf("%s wb_valid", tag),    64'(wb_valid),    64'd0);
    check($sformatf("%s status_wren", tag), 64'(status_wren), 64'd0);
  endtask

  int            lat, starts, start_at, steps;
  logic          stall_bad, wren;
  logic [W-1:0]  data;
  logic [RB-1:0] r;
  logic [31:0]   st;
  int            bad;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd6,        32'd7,       5'd5,  33, 32'd42,        1'b0, 32'd0, 1, 32};
    vecs[1] = '{1'b1, 32'd100,      32'd0,       5'd7,  1,  32'd0,         1'b1, 32'd2, 0, 0};
    vecs[2] = '{1'b0, 32'h10000,    32'h10000,   5'd9,  33, 32'd0,         1'b1, 32'd1, 1, 32};
    vecs[3] = '{1'b1, 32'd100,      32'd7,       5'd3,  33, 32'd14,        1'b0, 32'd0, 1, 32};
    if (EO) vecs[4] = '{1'b0, 32'd0, 32'd12345, 5'd2,  1,  32'd0,         1'b0, 32'd0, 0, 0};
    else    vecs[4] = '{1'b0, 32'd0, 32'd12345, 5'd2,  33, 32'd0,         1'b0, 32'd0, 1, 32};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'd2,       5'd11, 33, 32'hFFFFFFFE,  1'b1, 32'd1, 1, 32};
    vecs[6] = '{1'b1, 32'd0,        32'd0,       5'd31, 1,  32'd0,         1'b1, 32'd2, 0, 0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_idle("reset");
    check("reset dp_start",    64'(dp_start),    64'd0);
    check("reset dp_step",     64'(dp_step),     64'd0);
    check("reset dp_is_div",   64'(dp_is_div),   64'd0);
    check("reset dp_a",        64'(dp_a),        64'd0);
    check("reset dp_b",        64'(dp_b),        64'd0);
    check("reset wb_data",     64'(wb_data),     64'd0);
    check("reset wb_reg",      64'(wb_reg),      64'd0);
    check("reset status_data", 64'(status_data), 64'd0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      issue_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].dest, $sformatf("v%0d", i));
      watch(lat, starts, start_at, steps, stall_bad, data, r, wren, st);
      check($sformatf("v%0d latency", i),   64'(lat),       64'(vecs[i].lat));
      check($sformatf("v%0d wb_data", i),   64'(data),      64'(vecs[i].data));
      check($sformatf("v%0d wb_reg", i),    64'(r),         64'(vecs[i].dest));
      check($sformatf("v%0d wren", i),      64'(wren),      64'(vecs[i].wren));
      check($sformatf("v%0d status", i),    64'(st),        64'(vecs[i].status));
      check($sformatf("v%0d starts", i),    64'(starts),    64'(vecs[i].starts));
      check($sformatf("v%0d start_at", i),  64'(start_at),  64'(vecs[i].starts));
      check($sformatf("v%0d steps", i),     64'(steps),     64'(vecs[i].steps));
      check($sformatf("v%0d stall", i),     64'(stall_bad), 64'd0);
      @(negedge clock);
      check_idle($sformatf("v%0d after", i));
    end

    // Back-to-back: second issue presented in the FINISH cycle of the first.
    @(negedge clock);
    issue_op(1'b0, 32'd6, 32'd7, 5'd1, "b2b1");
    watch(lat, starts, start_at, steps, stall_bad, data, r, wren, st);
    check("b2b1 latency", 64'(lat),  64'd33);
    check("b2b1 wb_data", 64'(data), 64'd42);
    check("b2b1 wb_reg",  64'(r),    64'd1);
    issue_op(1'b0, 32'd3, 32'd5, 5'd4, "b2b2");
    watch(lat, starts, start_at, steps, stall_bad, data, r, wren, st);
    check("b2b2 start_at", 64'(start_at),  64'd1);
    check("b2b2 latency",  64'(lat),       64'd33);
    check("b2b2 wb_data",  64'(data),      64'd15);
    check("b2b2 wb_reg",   64'(r),         64'd4);
    check("b2b2 steps",    64'(steps),     64'd32);
    check("b2b2 stall",    64'(stall_bad), 64'd0);

    // Reset in the 10th RUN cycle aborts the operation.
    @(negedge clock);
    issue_op(1'b0, 32'd6, 32'd7, 5'd6, "abort");
    repeat (10) @(negedge clock);
    check("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle("abort");
    check("abort dp_step",  64'(dp_step),  64'd0);
    check("abort dp_start", 64'(dp_start), 64'd0);
    check("abort dp_a",     64'(dp_a),     64'd0);
    check("abort wb_reg",   64'(wb_reg),   64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (wb_valid !== 1'b0 || status_wren !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort no_wb", 64'(bad), 64'd0);
    @(negedge clock);
    issue_op(1'b0, 32'd2, 32'd3, 5'd6, "post");
    watch(lat, starts, start_at, steps, stall_bad, data, r, wren, st);
    check("post latency", 64'(lat),  64'd33);
    check("post wb_data", 64'(data), 64'd6);
    check("post steps",   64'(steps), 64'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controller that sequences the iterative multiply/divide datapath behind the execute stage.
- Accepts a mult/div issue from the decode/execute boundary and stalls the front of the pipeline (PC, FD, DE) while the datapath iterates.
- Drives the datapath's start/step controls and returns the result for writeback.
- Produces the status-register write: 1 = mult overflow, 2 = divide by zero.

Parameters:
- WIDTH, 32, operand/result width
- ITER_CYCLES, 32, datapath step cycles per operation (must be >=1)
- REG_BITS, 5, destination register index width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- issue  in  1  mult/div instruction present in execute stage
- is_div  in  1  1 = divide, 0 = multiply (sampled with issue)
- op_a  in  WIDTH  operand A, after bypass
- op_b  in  WIDTH  operand B, after bypass
- dest  in  REG_BITS  destination register
- stall  out  1  hold PC/FD/DE, insert noop downstream
- busy  out  1  operation in flight
- dp_start  out  1  one-cycle load pulse to datapath
- dp_is_div  out  1  operation select to datapath
- dp_a  out  WIDTH  latched operand A
- dp_b  out  WIDTH  latched operand B
- dp_step  out  1  advance datapath one iteration
- dp_result  in  WIDTH  datapath result, valid in FINISH
- dp_overflow  in  1  multiply overflow, valid in FINISH
- wb_valid  out  1  one-cycle result strobe
- wb_data  out  WIDTH  result
- wb_reg  out  REG_BITS  destination of result
- status_wren  out  1  status register write enable
- status_data  out  32  status value

Behaviour:
- Reset (synchronous, active-high): state IDLE, count 0, every registered output 0; stall = 0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - stall = issue (combinational).
  - On issue: latch op_a/op_b/is_div/dest into dp_a/dp_b/dp_is_div/wb_reg.
  - Divide with op_b == 0: go to FINISH with exception flag div0, no dp_start.
  - Otherwise: go to RUN, count = ITER_CYCLES-1.
- RUN:
  - stall = 1, busy = 1, dp_step = 1 every cycle.
  - dp_start = 1 only in the first RUN cycle; dp_step is also 1 in that cycle.
  - count decrements each cycle; at count == 0, go to FINISH.
  - issue is ignored in RUN.
- FINISH (exactly one cycle):
  - wb_valid = 1; stall = 0; busy = 0.
  - wb_data = dp_result, or 0 on div0.
  - status_wren = div0 | (~dp_is_div & dp_overflow).
  - status_data: 2 on div0, else 1 on overflow, else 0.
  - Next state IDLE. If issue = 1 in FINISH, accept it exactly as IDLE would (back-to-back), including combinational stall.
- Latency, issue to wb_valid: ITER_CYCLES+1 cycles normally; 1 cycle for div0.
- Count width is $clog2(ITER_CYCLES), minimum 1 bit. Count stops at 0; it never underflows.
- Reset in RUN or FINISH aborts the operation: no wb_valid, no status_wren.
- dp_a/dp_b stay stable from dp_start until FINISH ends.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a multiply with op_a == 0 or op_b == 0 goes IDLE -> FINISH directly, with no dp_start and no dp_step. Result is 0, no overflow, latency 1.
- Undefined: every multiply takes the full ITER_CYCLES+1 latency.

Decomposition:
- Package muldiv_pkg:
  - state encoding (IDLE/RUN/FINISH)
  - STATUS_MULT_OVF = 32'd1
  - STATUS_DIV_ZERO = 32'd2
  - default ITER_CYCLES
- Sub-module muldiv_iter_counter: loadable down-counter with a zero flag. Ports: clock, reset, load, load_val, en, count, zero.

Test Plan:
- Mult 6*7, ITER_CYCLES=32, model datapath: stall high for cycles t..t+32; dp_start only at t+1; 32 dp_step pulses; wb_valid at t+33 with wb_data=42, wb_reg=dest; status_wren=0.
- Div 100/0: wb_valid at t+1 with wb_data=0; status_wren=1, status_data=2; dp_start and dp_step never asserted.
- Mult 0x10000*0x10000 with dp_overflow=1 in FINISH: status_wren=1, status_data=1, wb_valid=1.
- Second issue asserted in the FINISH cycle: first wb_valid at t+33, second operation's dp_start at t+34, second wb_valid at t+66.
- Reset asserted in the 10th RUN cycle: next cycle state IDLE and all outputs 0; no wb_valid follows; a new issue then runs the full latency.
- With MULDIV_EARLY_OUT_EN, mult 0*12345: wb_valid at t+1 with wb_data=0, no dp_start. Without the macro, wb_valid at t+33.
